apb_cmd_master: RTL and testbench

//  APB initiator driving the top-level register slave (paddr[11:2], 32-bit data) from a command stream.

---
 rtl/apb_cmd_master_if.sv | 38 +++
 rtl/apb_cmd_master.sv | 109 ++++++++++
 tb/tb_apb_cmd_master.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// Command/response stream plus APB bus for apb_cmd_master.
// The master modport is the initiator's view; the slave modport is the host and APB target side.
interface apb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tout;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB initiator: turns one host command into one APB transfer and returns one response.
// ACCESS is bounded by a wait-state timeout that aborts the transfer and flags it on the response.
module apb_cmd_master #(
  parameter int D       = 0,
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              timeout_hit;

  // Reject parameter sets the counter cannot represent.
  generate
    if (D < 0 || TIMEOUT < 0 || (TIMEOUT > 0 && (TIMEOUT - 1) >= (1 << TO_W))) begin : g_bad_params
      $error("apb_cmd_master: TO_W too small for TIMEOUT, or negative D/TIMEOUT");
    end
  endgenerate

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT - 1));
    end
  endgenerate

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg     <= IDLE;
      to_cnt_reg    <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_tout  <= 1'b0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // cmd_ready is a register: it rises one cycle after reset or a consumed response.
          if (bus.cmd_ready && bus.cmd_valid) begin
            bus.pwrite    <= bus.cmd_write;
            bus.paddr     <= bus.cmd_addr;
            bus.pwdata    <= bus.cmd_wdata;
            bus.psel      <= 1'b1;
            bus.cmd_ready <= 1'b0;
            state_reg     <= SETUP;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          to_cnt_reg  <= '0;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave beats a timeout expiring on the same edge.
          if (bus.pready) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= bus.pwrite ? 32'h0 : bus.prdata;
            bus.rsp_err   <= bus.pslverr;
            bus.rsp_tout  <= 1'b0;
            state_reg     <= RESP;
          end else if (timeout_hit) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_tout  <= 1'b1;
            state_reg     <= RESP;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with TIMEOUT=8; the bench acts as host and APB slave.
module tb_apb_cmd_master;
  logic pclk;
  logic presetn;
  int   n_cmp;
  int   n_bad;

  apb_cmd_master_if bus ();

  apb_cmd_master #(.D(0), .TIMEOUT(8), .TO_W(4)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Present a command while cmd_ready is high; returns just after the accepting edge.
  task automatic issue(input logic w, input logic [9:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", {31'h0, bus.cmd_ready}, 32'h1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("consume_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    presetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_psel",      {31'h0, bus.psel}, 32'h0);
    chk("rst_penable",   {31'h0, bus.penable}, 32'h0);
    chk("rst_paddr",     {22'h0, bus.paddr}, 32'h0);
    chk("rst_pwdata",    bus.pwdata, 32'h0);
    presetn = 1'b1;
    tick();
    chk("idle_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);

    // 1: zero-wait write
    bus.pready = 1'b1;
    issue(1'b1, 10'h010, 32'hA5A5_0001);
    chk("t1_setup_psel",    {31'h0, bus.psel}, 32'h1);
    chk("t1_setup_penable", {31'h0, bus.penable}, 32'h0);
    chk("t1_setup_cmd_rdy", {31'h0, bus.cmd_ready}, 32'h0);
    chk("t1_paddr",         {22'h0, bus.paddr}, 32'h010);
    chk("t1_pwrite",        {31'h0, bus.pwrite}, 32'h1);
    chk("t1_pwdata",        bus.pwdata, 32'hA5A5_0001);
    tick();
    chk("t1_access_penable", {31'h0, bus.penable}, 32'h1);
    chk("t1_access_rsp_v",   {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    chk("t1_resp_valid",   {31'h0, bus.rsp_valid}, 32'h1);
    chk("t1_resp_psel",    {31'h0, bus.psel}, 32'h0);
    chk("t1_resp_penable", {31'h0, bus.penable}, 32'h0);
    chk("t1_resp_err",     {31'h0, bus.rsp_err}, 32'h0);
    chk("t1_resp_rdata",   bus.rsp_rdata, 32'h0);
    chk("t1_paddr_hold",   {22'h0, bus.paddr}, 32'h010);
    consume();
    chk("t1_back_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);

    // 2: read with three wait states
    bus.pready = 1'b0;
    bus.prdata = 32'h1234_5678;
    issue(1'b0, 10'h020, 32'hFFFF_FFFF);
    chk("t2_setup_penable", {31'h0, bus.penable}, 32'h0);
    chk("t2_pwrite",        {31'h0, bus.pwrite}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.pready = 1'b1;
      chk($sformatf("t2_access%0d_penable", i), {31'h0, bus.penable}, 32'h1);
      chk($sformatf("t2_access%0d_rsp_v", i), {31'h0, bus.rsp_valid}, 32'h0);
    end
    tick();
    chk("t2_resp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("t2_resp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("t2_resp_err",   {31'h0, bus.rsp_err}, 32'h0);
    chk("t2_resp_psel",  {31'h0, bus.psel}, 32'h0);
    consume();

    // 3: timeout after 8 ACCESS cycles
    bus.pready = 1'b0;
    bus.prdata = 32'hDEAD_BEEF;
    issue(1'b0, 10'h030, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t3_access%0d_psel", i), {31'h0, bus.psel}, 32'h1);
      chk($sformatf("t3_access%0d_penable", i), {31'h0, bus.penable}, 32'h1);
    end
    tick();
    chk("t3_resp_psel",  {31'h0, bus.psel}, 32'h0);
    chk("t3_resp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("t3_resp_err",   {31'h0, bus.rsp_err}, 32'h1);
    chk("t3_resp_tout",  {31'h0, bus.rsp_tout}, 32'h1);
    chk("t3_resp_rdata", bus.rsp_rdata, 32'h0);
    consume();

    // 4a: pready arrives on the timeout edge
    bus.prdata = 32'hCAFE_F00D;
    issue(1'b0, 10'h040, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) bus.pready = 1'b1;
      chk($sformatf("t4_access%0d_penable", i), {31'h0, bus.penable}, 32'h1);
    end
    tick();
    chk("t4a_resp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("t4a_resp_tout",  {31'h0, bus.rsp_tout}, 32'h0);
    chk("t4a_resp_err",   {31'h0, bus.rsp_err}, 32'h0);
    chk("t4a_resp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    consume();

    // 4b: pslverr on a write, then 5: stalled response
    bus.pslverr = 1'b1;
    issue(1'b1, 10'h3FF, 32'h0BAD_0BAD);
    tick();
    tick();
    bus.pslverr = 1'b0;
    chk("t4b_resp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("t4b_resp_err",   {31'h0, bus.rsp_err}, 32'h1);
    chk("t4b_resp_tout",  {31'h0, bus.rsp_tout}, 32'h0);
    chk("t4b_resp_rdata", bus.rsp_rdata, 32'h0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 10'h155;
    bus.cmd_wdata = 32'h0;
    bus.prdata    = 32'h0055_AA00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_stall%0d_rsp_v", i), {31'h0, bus.rsp_valid}, 32'h1);
      chk($sformatf("t5_stall%0d_err", i), {31'h0, bus.rsp_err}, 32'h1);
      chk($sformatf("t5_stall%0d_cmd_rdy", i), {31'h0, bus.cmd_ready}, 32'h0);
      chk($sformatf("t5_stall%0d_psel", i), {31'h0, bus.psel}, 32'h0);
      chk($sformatf("t5_stall%0d_paddr", i), {22'h0, bus.paddr}, 32'h3FF);
    end
    consume();
    chk("t5_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("t5_next_psel",  {31'h0, bus.psel}, 32'h1);
    chk("t5_next_paddr", {22'h0, bus.paddr}, 32'h155);
    tick();
    tick();
    chk("t5_next_rdata", bus.rsp_rdata, 32'h0055_AA00);
    chk("t5_next_err",   {31'h0, bus.rsp_err}, 32'h0);
    consume();

    // 6: asynchronous reset during ACCESS
    bus.pready = 1'b0;
    issue(1'b0, 10'h066, 32'h0);
    tick();
    chk("t6_access_penable", {31'h0, bus.penable}, 32'h1);
    #2;
    presetn = 1'b0;
    #1;
    chk("t6_async_psel",    {31'h0, bus.psel}, 32'h0);
    chk("t6_async_penable", {31'h0, bus.penable}, 32'h0);
    chk("t6_async_paddr",   {22'h0, bus.paddr}, 32'h0);
    tick();
    presetn = 1'b1;
    bus.pready = 1'b1;
    tick();
    chk("t6_idle_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_no_rsp%0d", i), {31'h0, bus.rsp_valid}, 32'h0);
      chk($sformatf("t6_no_psel%0d", i), {31'h0, bus.psel}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
